spi_master_ctrl: RTL and testbench
==================================

# spi_master_ctrl

SPI master transfer controller for the SPI peripheral, sitting directly upstream of the shifter. It runs on a single system clock and generates the serial clock (SCK) and slave select. It also produces the one-cycle Sample_clk/Shift_clk strobes, shifter_en and SPDR_wr_en that drive the shifter, and reports completion through SPIF. It supports all four CPOL/CPHA modes and a programmable SCK divider.

## Interface
Parameters:
- DWIDTH, 8, bits per transfer; must match the shifter.
- DIV_W, 8, width of Clk_div.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- SPE  input  1  SPI enable; low aborts any transfer.
- CPOL  input  1  SCK idle level.
- CPHA  input  1  0 = sample on leading edge; 1 = shift on leading edge.
- Clk_div  input  DIV_W  SCK half-period H = Clk_div+1 clk cycles.
- Start  input  1  one-cycle pulse requesting a transfer (SPDR written).
- SPIF_clr  input  1  clears SPIF and WCOL.
- SCK  output  1  serial clock.
- SS_n  output  1  slave select, active low.
- Sample_clk  output  1  one-cycle strobe; the shifter captures Data_in.
- Shift_clk  output  1  one-cycle strobe; the shifter drives the next bit out.
- shifter_en  output  1  high while busy.
- SPDR_wr_en  output  1  one-cycle strobe; shifter contents are copied to SPDR.
- SPIF  output  1  sticky transfer-complete flag.
- WCOL  output  1  sticky write-collision flag.
- Busy  output  1  transfer in progress.

## Operation
- Reset values: SCK=0, SS_n=1, SPIF=0, WCOL=0, Busy=0, shifter_en=0. All strobes are 0. FSM is in IDLE; counters are 0.
- FSM states: IDLE, SETUP, XFER, DONE.
- IDLE:
  - SCK follows CPOL.
  - Start with SPE=1 latches CPOL, CPHA and Clk_div, then moves to SETUP.
  - Start with SPE=0 is ignored.
- SETUP (H cycles):
  - SS_n=0, Busy=1, shifter_en=1.
  - If CPHA=0, Shift_clk pulses in the first SETUP cycle so the MSB is presented before the first edge.
- XFER:
  - SCK toggles every H cycles, for 2·DWIDTH edges in total.
  - Odd edges are leading edges; even edges are trailing edges.
  - CPHA=0: Sample_clk pulses on leading edges and Shift_clk on trailing edges. The Shift_clk on the final trailing edge is suppressed.
  - CPHA=1: Shift_clk pulses on leading edges and Sample_clk on trailing edges.
  - A bit counter of width clog2(DWIDTH)+1 counts Sample_clk pulses. Exactly DWIDTH samples occur per transfer.
- DONE:
  - Entered H cycles after the last edge and lasts one cycle.
  - SPDR_wr_en=1, SS_n=1, SPIF is set. The FSM then returns to IDLE and Busy=0.
- Boundary conditions:
  - Start while Busy=1: ignored, and WCOL is set.
  - SPE deasserted in any non-IDLE state: go to IDLE next cycle with SCK=CPOL and SS_n=1. No SPIF and no SPDR_wr_en are issued.
  - Input config changes during a transfer have no effect, because the latched copy is used.
  - SPIF_clr in the same cycle as an SPIF/WCOL set: the set wins.
  - Start in the same cycle as DONE: treated as busy, so WCOL is set.
  - Clk_div=0: H=1, giving SCK = clk/2.
  - rst_n low mid-transfer: immediate return to reset values with no strobes.

## Timing
- Start is sampled at cycle 0.
- SETUP occupies cycles 1..H.
- Edge k (k=1..2·DWIDTH) occurs at cycle 1+k·H. The SCK toggle and the associated strobe are registered in the same cycle.
- DONE occurs at cycle 1+(2·DWIDTH+1)·H.
- IDLE is re-entered the next cycle, when Busy falls.
- Strobes are exactly one clk cycle wide and never overlap.
- Earliest accepted back-to-back Start: the cycle after DONE.

## Test plan
- CPOL=0, CPHA=0, Clk_div=1, DWIDTH=8, Start at cycle 0 -> the following response:
  - Shift_clk at cycle 1.
  - SCK rises at 3, 7, …, 31 and falls at 5, …, 33.
  - 8 Sample_clk pulses at rises and 7 Shift_clk pulses at falls 5..29.
  - SPDR_wr_en and SPIF at cycle 35; SS_n=0 from cycle 1 to 34.
- CPOL=1, CPHA=1, Clk_div=0 -> the following response:
  - SCK idles at 1 and first falls at cycle 2 with Shift_clk.
  - Sample_clk on rises at 3, 5, …, 17.
  - DONE at cycle 18.
- Start at cycle 10 during a transfer -> WCOL=1 and the transfer completes unchanged. SPIF_clr then clears both SPIF and WCOL.
- SPE dropped at cycle 12 mid-transfer -> at cycle 13 SS_n=1, SCK=CPOL, Busy=0. No SPIF and no SPDR_wr_en.
- rst_n asserted mid-transfer -> all outputs go to reset values asynchronously. A new Start after release runs a full transfer.
- Sweep all 4 CPOL/CPHA modes with Clk_div=3, with the bench connected to a loopback shifter model -> received byte equals transmitted byte (e.g. 0xA5).

Source files
------------

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI master transfer sequencer generating SCK, SS_n and shifter strobes
// Ports: clk/rst_n clock and async active-low reset; SPE enable; CPOL/CPHA mode;
// Clk_div sets SCK half-period (Clk_div+1 clks); Start/SPIF_clr requests; SCK/SS_n serial
// outputs; Sample_clk/Shift_clk/SPDR_wr_en/shifter_en drive the shifter; SPIF/WCOL/Busy status.
module spi_master_ctrl #(
    parameter int DWIDTH = 8,
    parameter int DIV_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SPE,
    input  logic             CPOL,
    input  logic             CPHA,
    input  logic [DIV_W-1:0] Clk_div,
    input  logic             Start,
    input  logic             SPIF_clr,
    output logic             SCK,
    output logic             SS_n,
    output logic             Sample_clk,
    output logic             Shift_clk,
    output logic             shifter_en,
    output logic             SPDR_wr_en,
    output logic             SPIF,
    output logic             WCOL,
    output logic             Busy
);
    localparam int EW = $clog2(2 * DWIDTH) + 1;
    localparam int BW = $clog2(DWIDTH) + 1;
    localparam logic [EW-1:0] LAST = EW'(2 * DWIDTH);
    typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} state_t;
    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
    logic [EW-1:0]    edges_q, edges_d, nxt_edge;
    logic [BW-1:0]    bits_q, bits_d;
    logic             cpol_q, cpol_d, cpha_q, cpha_d, sck_q, sck_d;
    logic             sample_q, sample_d, shift_q, shift_d, wr_q, wr_d;
    logic             spif_q, spif_d, wcol_q, wcol_d;
    logic             lead, tick;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            edges_q  <= '0;
            bits_q   <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            sck_q    <= 1'b0;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
            wr_q     <= 1'b0;
            spif_q   <= 1'b0;
            wcol_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            edges_q  <= edges_d;
            bits_q   <= bits_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            sck_q    <= sck_d;
            sample_q <= sample_d;
            shift_q  <= shift_d;
            wr_q     <= wr_d;
            spif_q   <= spif_d;
            wcol_q   <= wcol_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        edges_d  = edges_q;
        bits_d   = bits_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        sck_d    = sck_q;
        sample_d = 1'b0;
        shift_d  = 1'b0;
        wr_d     = 1'b0;
        nxt_edge = edges_q + 1'b1;
        lead     = nxt_edge[0];
        tick     = cnt_q == div_q;
        spif_d   = SPIF_clr ? 1'b0 : spif_q;
        // a set always beats a simultaneous clear
        wcol_d   = (Start && state_q != IDLE) ? 1'b1 : SPIF_clr ? 1'b0 : wcol_q;
        if (state_q != IDLE && !SPE) begin
            state_d = IDLE;
            sck_d   = CPOL;
        end else if (state_q == IDLE) begin
            sck_d = CPOL;
            if (Start && SPE) begin
                state_d = SETUP;
                cpol_d  = CPOL;
                cpha_d  = CPHA;
                div_d   = Clk_div;
                cnt_d   = '0;
                edges_d = '0;
                bits_d  = '0;
                // CPHA=0 needs the MSB on the line before the first edge
                shift_d = !CPHA;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end else begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick && edges_q == LAST) begin
                state_d = DONE;
                wr_d    = 1'b1;
                spif_d  = 1'b1;
            end else if (tick) begin
                state_d  = XFER;
                edges_d  = nxt_edge;
                sck_d    = cpol_q ^ lead;
                sample_d = cpha_q ? !lead : lead;
                // no shift after the final trailing edge: nothing is left to present
                shift_d  = cpha_q ? lead : (!lead && nxt_edge != LAST);
                bits_d   = bits_q + BW'(sample_d);
            end
        end
    end
    assign SCK        = sck_q;
    assign SS_n       = !(state_q == SETUP || state_q == XFER);
    assign Busy       = state_q != IDLE;
    assign shifter_en = Busy;
    assign Sample_clk = sample_q;
    assign Shift_clk  = shift_q;
    assign SPDR_wr_en = wr_q;
    assign SPIF       = spif_q;
    assign WCOL       = wcol_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: randomized self-checking bench with cycle-formula reference and loopback shifter
module tb_spi_master_ctrl;
    logic       clk = 0, rst_n = 0, SPE = 1, CPOL = 0, CPHA = 0, Start = 0, SPIF_clr = 0;
    logic [7:0] Clk_div = 0;
    logic       SCK, SS_n, Sample_clk, Shift_clk, shifter_en, SPDR_wr_en, SPIF, WCOL, Busy;
    logic [8:0] obs;
    logic [7:0] tx_byte = 0, tx_sr = 0, rx_sr = 0;
    logic       mosi = 0, load = 0;
    int         n_chk = 0, n_pass = 0;
    localparam logic [8:0] RST_VEC = 9'b010000000;

    always #5 clk = ~clk;

    spi_master_ctrl #(.DWIDTH(8), .DIV_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .SPE(SPE), .CPOL(CPOL), .CPHA(CPHA), .Clk_div(Clk_div),
        .Start(Start), .SPIF_clr(SPIF_clr), .SCK(SCK), .SS_n(SS_n), .Sample_clk(Sample_clk),
        .Shift_clk(Shift_clk), .shifter_en(shifter_en), .SPDR_wr_en(SPDR_wr_en),
        .SPIF(SPIF), .WCOL(WCOL), .Busy(Busy)
    );

    assign obs = {SCK, SS_n, Sample_clk, Shift_clk, SPDR_wr_en, SPIF, WCOL, Busy, shifter_en};

    // loopback shifter: MOSI wired straight back to MISO
    always @(posedge clk) begin
        if (load) tx_sr <= tx_byte;
        else if (Shift_clk) begin
            mosi  <= tx_sr[7];
            tx_sr <= tx_sr << 1;
        end
        if (Sample_clk) rx_sr <= {rx_sr[6:0], mosi};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Start is high in cycle 0; every later cycle t is checked mid-cycle and inputs for t are driven.
    task automatic run_xfer(input logic cpol, input logic cpha, input logic [7:0] div, input logic [7:0] tx,
                            input int wcol_t, input int abort_t, input bit race, input bit jitter);
        int  h, d, last, n, k;
        bit  ab, valid;
        logic sck, ss, smp, shf, wr, spif, wcol, busy;
        h    = int'(div) + 1;
        d    = 1 + 17 * h;
        last = abort_t > 0 ? abort_t + 3 : d + 1;
        @(negedge clk);
        SPIF_clr = 1; CPOL = cpol; CPHA = cpha; Clk_div = div; SPE = 1;
        @(negedge clk);
        SPIF_clr = 0; Start = 1; load = 1; tx_byte = tx;
        for (int t = 1; t <= last; t++) begin
            @(negedge clk);
            ab    = abort_t > 0 && t > abort_t;
            n     = (t - 1) / h;
            if (n > 16) n = 16;
            k     = ((t - 1) % h == 0) ? (t - 1) / h : 0;
            valid = k >= 1 && k <= 16;
            sck   = (ab || t > d) ? cpol : cpol ^ (n % 2 == 1);
            smp   = !ab && valid && (cpha ? k % 2 == 0 : k % 2 == 1);
            shf   = !ab && ((t == 1 && !cpha) || (valid && (cpha ? k % 2 == 1 : (k % 2 == 0 && k != 16))));
            wr    = !ab && t == d;
            spif  = !ab && t >= d;
            busy  = !ab && t <= d;
            ss    = !(!ab && t < d);
            wcol  = wcol_t > 0 && t > wcol_t;
            check($sformatf("trace m%0d%0d div%0d t=%0d", cpol, cpha, div, t), obs,
                  {sck, ss, smp, shf, wr, spif, wcol, busy, busy});
            if (t == d && abort_t == 0) check($sformatf("loopback tx=%0h", tx), rx_sr, tx);
            Start    = t == wcol_t;
            load     = 0;
            SPE      = !(abort_t > 0 && t >= abort_t);
            SPIF_clr = race && t == d - 1;
            if (jitter && t < d - 2) begin
                CPOL    = 1'($urandom);
                CPHA    = 1'($urandom);
                Clk_div = 8'($urandom);
            end else begin
                CPOL = cpol; CPHA = cpha; Clk_div = div;
            end
        end
        Start = 0; SPE = 1; SPIF_clr = 0;
    endtask

    initial begin
        #1 check("reset async", obs, RST_VEC);
        repeat (2) @(negedge clk);
        check("reset held", obs, RST_VEC);
        rst_n = 1;
        run_xfer(0, 0, 8'd1, 8'hA5, 0, 0, 1, 0);
        run_xfer(1, 1, 8'd0, 8'h3C, 0, 0, 0, 0);
        run_xfer(0, 0, 8'd1, 8'h5A, 10, 0, 0, 0);
        @(negedge clk);
        check("flags before clr", {SPIF, WCOL}, 2'b11);
        SPIF_clr = 1;
        @(negedge clk);
        SPIF_clr = 0;
        check("flags after clr", {SPIF, WCOL}, 2'b00);
        run_xfer(1, 0, 8'd0, 8'h99, 18, 0, 0, 0);
        run_xfer(0, 1, 8'd1, 8'hC3, 0, 12, 0, 0);
        @(negedge clk);
        SPE = 0; Start = 1;
        @(negedge clk);
        Start = 0;
        check("start spe0 busy", Busy, 1'b0);
        @(negedge clk);
        check("start spe0 ss", SS_n, 1'b1);
        SPE = 1; CPOL = 1; CPHA = 0; Clk_div = 2; Start = 1;
        @(negedge clk);
        Start = 0;
        repeat (6) @(negedge clk);
        check("mid busy", Busy, 1'b1);
        rst_n = 0;
        #1 check("mid reset", obs, RST_VEC);
        @(negedge clk);
        check("mid reset held", obs, RST_VEC);
        rst_n = 1;
        run_xfer(1, 0, 8'd2, 8'h81, 0, 0, 0, 0);
        for (int m = 0; m < 4; m++) run_xfer(m[1], m[0], 8'd3, 8'hA5, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            run_xfer(1'($urandom), 1'($urandom), 8'($urandom_range(0, 4)), 8'($urandom),
                     0, 0, 1'($urandom), 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
